// File: rtl/proc_sched_pkg.sv
// Shared constants and types for the proc_sched round-robin dispatcher.
package proc_sched_pkg;

  localparam int unsigned PROC_ID_W = 5;

  // Control word bit positions in data_in[7:0]
  localparam int unsigned PS_SET_PEND = 0;
  localparam int unsigned PS_CLR_PEND = 1;
  localparam int unsigned PS_SET_EN   = 2;
  localparam int unsigned PS_CLR_EN   = 3;
  localparam int unsigned PS_CLR_ALL  = 4;
  localparam int unsigned PS_CLR_OVR  = 5;

  localparam logic [1:0] PS_ADR_OFFER = 2'd0;
  localparam logic [1:0] PS_ADR_EN    = 2'd1;
  localparam logic [1:0] PS_ADR_OVR   = 2'd2;

  typedef enum logic {
    PS_IDLE  = 1'b0,
    PS_OFFER = 1'b1
  } ps_state_e;

endpackage

// File: rtl/proc_sched_rr_pick.sv
// rr_pick: combinational rotate-priority encoder; first set req at or after ptr, wrapping.
module rr_pick
  import proc_sched_pkg::*;
#(
  parameter int unsigned NUM_PROC = 16
) (
  input  logic [NUM_PROC-1:0]  req,
  input  logic [PROC_ID_W-1:0] ptr,
  output logic                 any,
  output logic [PROC_ID_W-1:0] id
);

  localparam int unsigned IDX_W = PROC_ID_W + 1;

  logic [31:0]      req_ext;
  logic [IDX_W-1:0] idx;

  assign req_ext = 32'(req);

  // ptr is always below NUM_PROC, so one conditional subtract is enough to wrap
  always_comb begin
    any = 1'b0;
    id  = '0;
    idx = '0;
    for (int unsigned k = 0; k < NUM_PROC; k++) begin
      idx = IDX_W'(ptr) + IDX_W'(k);
      if (idx >= IDX_W'(NUM_PROC)) idx = idx - IDX_W'(NUM_PROC);
      if (!any && req_ext[idx[PROC_ID_W-1:0]]) begin
        any = 1'b1;
        id  = idx[PROC_ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/proc_sched.sv
// proc_sched: latches proc_rdy rising edges and offers one process id at a time, round-robin.
// Optional sticky overrun map enabled by defining PROC_SCHED_OVERRUN_EN.
module proc_sched
  import proc_sched_pkg::*;
#(
  parameter int unsigned NUM_PROC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic                rd,
  input  logic [1:0]          adr,
  input  logic [31:0]         data_in,
  input  logic [NUM_PROC-1:0] proc_rdy,
  output logic [31:0]         data_out,
  output logic                irq
);

  localparam int unsigned IDX_W = PROC_ID_W + 1;
  localparam int unsigned CNT_W = 6;

  ps_state_e            state_q, state_d;
  logic [NUM_PROC-1:0]  rdy_q, rdy_d;
  logic [NUM_PROC-1:0]  pending_q, pending_d;
  logic [NUM_PROC-1:0]  enable_q, enable_d;
  logic [PROC_ID_W-1:0] ptr_q, ptr_d;
  logic [PROC_ID_W-1:0] offer_id_q, offer_id_d;

  logic [7:0]           ctrl;
  logic [PROC_ID_W-1:0] wr_id;
  logic [NUM_PROC-1:0]  id_mask, offer_mask, rise, set_mask, clr_mask, elig_q, elig_d;
  logic                 valid, consume, pick_any;
  logic [PROC_ID_W-1:0] pick_id;
  logic [IDX_W-1:0]     ptr_inc;
  logic [CNT_W-1:0]     pend_cnt;
  logic [4:0]           pend_sat;
  logic [31:0]          ovr_rd;
  logic                 unused_bits;

  assign ctrl       = data_in[7:0];
  assign wr_id      = data_in[12:8];
  assign id_mask    = (IDX_W'(wr_id) < IDX_W'(NUM_PROC)) ? (NUM_PROC'(1) << wr_id) : '0;
  assign offer_mask = NUM_PROC'(1) << offer_id_q;
  assign rise       = proc_rdy & ~rdy_q;
  assign valid      = (state_q == PS_OFFER);
  assign consume    = valid & rd & (adr == PS_ADR_OFFER);
  assign elig_q     = pending_q & enable_q;
  assign ptr_inc    = IDX_W'(offer_id_q) + IDX_W'(1);
  assign irq        = valid;

  rr_pick #(.NUM_PROC(NUM_PROC)) u_pick (
    .req (elig_q),
    .ptr (ptr_q),
    .any (pick_any),
    .id  (pick_id)
  );

  // Sets are OR-ed in after clears so a same-cycle set always wins; disable beats enable
  always_comb begin
    rdy_d      = proc_rdy;
    set_mask   = rise | ({NUM_PROC{wr & ctrl[PS_SET_PEND]}} & id_mask);
    clr_mask   = ({NUM_PROC{consume}} & offer_mask)
               | ({NUM_PROC{wr & ctrl[PS_CLR_PEND]}} & id_mask)
               | {NUM_PROC{wr & ctrl[PS_CLR_ALL]}};
    pending_d  = (pending_q & ~clr_mask) | set_mask;
    enable_d   = (enable_q | ({NUM_PROC{wr & ctrl[PS_SET_EN]}} & id_mask))
               & ~({NUM_PROC{wr & ctrl[PS_CLR_EN]}} & id_mask);
    elig_d     = pending_d & enable_d;
    state_d    = state_q;
    ptr_d      = ptr_q;
    offer_id_d = offer_id_q;
    case (state_q)
      PS_IDLE: begin
        if (pick_any) begin
          state_d    = PS_OFFER;
          offer_id_d = pick_id;
        end
      end
      PS_OFFER: begin
        if (consume) begin
          state_d = PS_IDLE;
          ptr_d   = (ptr_inc >= IDX_W'(NUM_PROC)) ? '0 : ptr_inc[PROC_ID_W-1:0];
        end else if ((elig_d & offer_mask) == '0) begin
          state_d = PS_IDLE;
        end
      end
      default: state_d = PS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PS_IDLE;
      rdy_q      <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      ptr_q      <= '0;
      offer_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      ptr_q      <= ptr_d;
      offer_id_q <= offer_id_d;
    end
  end

`ifdef PROC_SCHED_OVERRUN_EN
  logic [NUM_PROC-1:0] overrun_q, overrun_d;

  // A rise on an id still pending (and not leaving this cycle) is a lost dispatch
  always_comb begin
    overrun_d = (overrun_q & ~{NUM_PROC{wr & ctrl[PS_CLR_OVR]}})
              | (rise & pending_q & ~({NUM_PROC{consume}} & offer_mask));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun_q <= '0;
    else     overrun_q <= overrun_d;
  end

  assign ovr_rd      = 32'(overrun_q);
  assign unused_bits = ^{data_in[31:13], ctrl[7:6]};
`else
  assign ovr_rd      = '0;
  assign unused_bits = ^{data_in[31:13], ctrl[7:5]};
`endif

  always_comb begin
    pend_cnt = '0;
    for (int unsigned i = 0; i < NUM_PROC; i++) pend_cnt = pend_cnt + CNT_W'(pending_q[i]);
    pend_sat = (pend_cnt > CNT_W'(31)) ? 5'd31 : pend_cnt[4:0];
  end

  always_comb begin
    data_out = '0;
    case (adr)
      PS_ADR_OFFER: data_out = {valid, 10'd0, pend_sat, 11'd0, offer_id_q};
      PS_ADR_EN:    data_out = 32'(enable_q);
      PS_ADR_OVR:   data_out = ovr_rd;
      default:      data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_proc_sched.sv
// Directed self-checking bench for proc_sched (NUM_PROC = 16), with or without PROC_SCHED_OVERRUN_EN.
module tb_proc_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [1:0]  adr = 2'd0;
  logic [31:0] data_in = '0;
  logic [15:0] proc_rdy = '0;
  logic [31:0] data_out;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] v;

  proc_sched #(.NUM_PROC(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .rd       (rd),
    .adr      (adr),
    .data_in  (data_in),
    .proc_rdy (proc_rdy),
    .data_out (data_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [7:0] c, input logic [4:0] id);
    data_in = {19'd0, id, c};
    wr = 1'b1;
    cyc(1);
    wr = 1'b0;
    data_in = '0;
  endtask

  task automatic consume();
    adr = 2'd0;
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] i);
    proc_rdy[i] = 1'b1;
    cyc(1);
    proc_rdy[i] = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] r);
    adr = a;
    #1;
    r = data_out;
    adr = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
    read_reg(2'd0, v);
    n_checks++; if (v !== 32'h0) $display("FAIL reset_adr0: got %h want 00000000", v); else n_pass++;
    read_reg(2'd1, v);
    n_checks++; if (v !== 32'h0) $display("FAIL reset_adr1: got %h want 00000000", v); else n_pass++;
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_first_dispatch();
    do_write(8'h04, 5'd3);
    pulse(4'd3);
    n_checks++; if (irq !== 1'b0) $display("FAIL first_early_irq: got %b want 0", irq); else n_pass++;
    cyc(1);
    n_checks++; if (irq !== 1'b1) $display("FAIL first_irq: got %b want 1", irq); else n_pass++;
    read_reg(2'd0, v);
    n_checks++; if (v !== 32'h8001_0003) $display("FAIL first_offer: got %h want 80010003", v); else n_pass++;
    consume();
    n_checks++; if (irq !== 1'b0) $display("FAIL first_consume_irq: got %b want 0", irq); else n_pass++;
    read_reg(2'd0, v);
    n_checks++; if (v !== 32'h0000_0003) $display("FAIL first_after: got %h want 00000003", v); else n_pass++;
  endtask

  task automatic test_round_robin();
    do_write(8'h04, 5'd1);
    do_write(8'h04, 5'd5);
    do_write(8'h04, 5'd9);
    pulse(4'd5);
    cyc(1);
    read_reg(2'd0, v);
    n_checks++; if (v !== 32'h8001_0005) $display("FAIL rr_setup: got %h want 80010005", v); else n_pass++;
    consume();
    proc_rdy = 16'h0222;
    cyc(1);
    proc_rdy = '0;
    cyc(1);
    read_reg(2'd0, v);
    n_checks++; if (v !== 32'h8003_0009) $display("FAIL rr_offer0: got %h want 80030009", v); else n_pass++;
    consume();
    cyc(1);
    read_reg(2'd0, v);
    n_checks++; if (v !== 32'h8002_0001) $display("FAIL rr_offer1: got %h want 80020001", v); else n_pass++;
    consume();
    cyc(1);
    read_reg(2'd0, v);
    n_checks++; if (v !== 32'h8001_0005) $display("FAIL rr_offer2: got %h want 80010005", v); else n_pass++;
    consume();
    cyc(1);
    n_checks++; if (irq !== 1'b0) $display("FAIL rr_drained: got %b want 0", irq); else n_pass++;
  endtask

  task automatic test_held_level();
    int n;
    logic [4:0] last_id;
    n = 0;
    last_id = '0;
    do_write(8'h04, 5'd2);
    proc_rdy[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (irq) begin
        rd = 1'b1;
        n++;
        last_id = data_out[4:0];
      end else begin
        rd = 1'b0;
      end
      cyc(1);
    end
    rd = 1'b0;
    n_checks++; if (n !== 1) $display("FAIL held_count: got %0d want 1", n); else n_pass++;
    n_checks++; if (last_id !== 5'd2) $display("FAIL held_id: got %0d want 2", last_id); else n_pass++;
    proc_rdy[2] = 1'b0;
    cyc(1);
    proc_rdy[2] = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (irq) begin
        rd = 1'b1;
        n++;
      end else begin
        rd = 1'b0;
      end
      cyc(1);
    end
    rd = 1'b0;
    proc_rdy[2] = 1'b0;
    cyc(1);
    n_checks++; if (n !== 1) $display("FAIL retoggle_count: got %0d want 1", n); else n_pass++;
  endtask

  task automatic test_stable_offer();
    do_write(8'h04, 5'd7);
    do_write(8'h04, 5'd4);
    pulse(4'd7);
    cyc(1);
    read_reg(2'd0, v);
    n_checks++; if (v !== 32'h8001_0007) $display("FAIL stable_first: got %h want 80010007", v); else n_pass++;
    pulse(4'd4);
    cyc(1);
    read_reg(2'd0, v);
    n_checks++; if (v !== 32'h8002_0007) $display("FAIL stable_hold: got %h want 80020007", v); else n_pass++;
    do_write(8'h08, 5'd7);
    n_checks++; if (irq !== 1'b0) $display("FAIL disable_idle: got %b want 0", irq); else n_pass++;
    cyc(1);
    read_reg(2'd0, v);
    n_checks++; if (v !== 32'h8002_0004) $display("FAIL disable_next: got %h want 80020004", v); else n_pass++;
    consume();
    do_write(8'h02, 5'd7);
    do_write(8'h04, 5'd7);
    cyc(1);
    read_reg(2'd0, v);
    n_checks++; if (v[31:16] !== 16'h0000) $display("FAIL clr_pend: got %h want 0000xxxx", v); else n_pass++;
  endtask

  task automatic test_reraise_on_consume();
    pulse(4'd7);
    cyc(1);
    n_checks++; if (irq !== 1'b1) $display("FAIL reraise_offer: got %b want 1", irq); else n_pass++;
    rd = 1'b1;
    proc_rdy[7] = 1'b1;
    cyc(1);
    rd = 1'b0;
    proc_rdy[7] = 1'b0;
    n_checks++; if (irq !== 1'b0) $display("FAIL reraise_idle: got %b want 0", irq); else n_pass++;
    cyc(1);
    read_reg(2'd0, v);
    n_checks++; if (v !== 32'h8001_0007) $display("FAIL reraise_again: got %h want 80010007", v); else n_pass++;
    read_reg(2'd2, v);
    n_checks++; if (v !== 32'h0) $display("FAIL reraise_ovr: got %h want 00000000", v); else n_pass++;
    consume();
    cyc(1);
  endtask

  task automatic test_overrun();
    logic [31:0] exp_ovr;
`ifdef PROC_SCHED_OVERRUN_EN
    exp_ovr = 32'h1;
`else
    exp_ovr = 32'h0;
`endif
    do_write(8'h04, 5'd0);
    pulse(4'd0);
    cyc(1);
    pulse(4'd0);
    cyc(1);
    read_reg(2'd2, v);
    n_checks++; if (v !== exp_ovr) $display("FAIL ovr_set: got %h want %h", v, exp_ovr); else n_pass++;
    do_write(8'h20, 5'd0);
    read_reg(2'd2, v);
    n_checks++; if (v !== 32'h0) $display("FAIL ovr_clr: got %h want 00000000", v); else n_pass++;
    read_reg(2'd0, v);
    n_checks++; if (v !== 32'h8001_0000) $display("FAIL ovr_offer: got %h want 80010000", v); else n_pass++;
    consume();
    cyc(1);
    n_checks++; if (irq !== 1'b0) $display("FAIL ovr_drained: got %b want 0", irq); else n_pass++;
  endtask

  task automatic test_id_range();
    do_write(8'h05, 5'd31);
    cyc(1);
    read_reg(2'd1, v);
    n_checks++; if (v !== 32'h0000_02BF) $display("FAIL id31_en: got %h want 000002bf", v); else n_pass++;
    read_reg(2'd0, v);
    n_checks++; if (v !== 32'h0) $display("FAIL id31_pend: got %h want 00000000", v); else n_pass++;
    read_reg(2'd3, v);
    n_checks++; if (v !== 32'h0) $display("FAIL adr3: got %h want 00000000", v); else n_pass++;
  endtask

  task automatic test_conflicts();
    do_write(8'h0C, 5'd9);
    read_reg(2'd1, v);
    n_checks++; if (v !== 32'h0000_00BF) $display("FAIL en_dis_conflict: got %h want 000000bf", v); else n_pass++;
    do_write(8'h03, 5'd4);
    cyc(1);
    read_reg(2'd0, v);
    n_checks++; if (v !== 32'h8001_0004) $display("FAIL set_clr_conflict: got %h want 80010004", v); else n_pass++;
    do_write(8'h10, 5'd0);
    read_reg(2'd0, v);
    n_checks++; if (v !== 32'h0000_0004) $display("FAIL clr_all: got %h want 00000004", v); else n_pass++;
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
    cyc(1);
    read_reg(2'd0, v);
    n_checks++; if (v !== 32'h0000_0004) $display("FAIL idle_rd: got %h want 00000004", v); else n_pass++;
  endtask

  task automatic test_reset_mid_offer();
    pulse(4'd5);
    cyc(1);
    n_checks++; if (irq !== 1'b1) $display("FAIL mid_offer: got %b want 1", irq); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (irq !== 1'b0) $display("FAIL mid_rst_irq: got %b want 0", irq); else n_pass++;
    read_reg(2'd1, v);
    n_checks++; if (v !== 32'h0) $display("FAIL mid_rst_en: got %h want 00000000", v); else n_pass++;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    read_reg(2'd0, v);
    n_checks++; if (v !== 32'h0) $display("FAIL mid_rst_after: got %h want 00000000", v); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_dispatch();
    test_round_robin();
    test_held_level();
    test_stable_offer();
    test_reraise_on_consume();
    test_overrun();
    test_id_range();
    test_conflicts();
    test_reset_mid_offer();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/proc_sched.md
# proc_sched

Round-robin dispatcher for process-timer ready events. Sits on the IO bus beside `proctimers`, takes its `procRdy` vector, latches each rising edge as a pending dispatch, and offers the CPU one stable "next process" id at a time. The kernel reads the offer to consume it; the block advances its round-robin pointer past the consumed id.

## Interface
- `NUM_PROC`, default 16: number of process slots, 1..32; ids are 5 bits wide.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `wr`  in  1  IO write strobe, control word on `data_in`.
- `rd`  in  1  IO read strobe; consumes the offer only when `adr == 0`.
- `adr`  in  2  register select: 0 = offer, 1 = enable mask, 2 = overrun map.
- `data_in`  in  32  [7:0] ctrl, [12:8] process id.
- `proc_rdy`  in  NUM_PROC  ready levels from `proctimers`.
- `data_out`  out  32  read data, combinational from registered state.
- `irq`  out  1  offer valid.

## Operation
- Edge detect: `rdy_q <= proc_rdy`; `rise = proc_rdy & ~rdy_q` sets `pending[i]`. A held level never re-queues.
- Control bits, all qualified by `wr` and decoded in parallel:
  - ctrl[0] sets pending[id].
  - ctrl[1] clears pending[id].
  - ctrl[2] sets enable[id].
  - ctrl[3] clears enable[id].
  - ctrl[4] clears all pending.
  - ctrl[5] clears all overrun (macro only).
- Ids >= NUM_PROC are ignored.
- Eligible set = `pending & enable`. The winner is the first eligible id at or after `ptr`, wrapping modulo NUM_PROC.
- FSM, two states:
  - IDLE: `valid=0`. If any id is eligible, latch the winner into `offer_id` and go to OFFER.
  - OFFER: `valid=1`; `offer_id` is held stable.
    - `rd & adr==0`: clear pending[offer_id], set `ptr <= offer_id+1` (wrapping to 0 at NUM_PROC), go to IDLE.
    - If offer_id stops being eligible (cleared or disabled by a write): go to IDLE with no pointer change.
- Same-cycle conflicts:
  - A set of pending[i] (rise or ctrl[0]) in the same cycle as a clear (consume, ctrl[1], ctrl[4]) leaves pending[i]=1.
  - ctrl[2] and ctrl[3] together: disable wins.
- Reads:
  - adr 0: [31] valid, [20:16] pending popcount (saturating at 31), [4:0] offer_id.
  - adr 1: the enable mask.
  - adr 2: the overrun map, or 0 without the macro.
  - adr 3: 0.
- `irq` = valid.

## Timing
- All state resets asynchronously on `rst`: pending, enable, overrun, `rdy_q`, `ptr`, `offer_id` all 0; state IDLE.
- Reset values of outputs: `irq`=0, `data_out`=0.
- Latency, first dispatch:
  - `proc_rdy` rises in cycle t.
  - pending is set at edge t+1.
  - The block is in OFFER with `irq`=1 after edge t+2.
- Back-to-back: a consuming `rd` at edge t gives IDLE at t+1 and the next offer at t+2. Throughput is therefore one dispatch per 2 cycles.
- The offer is stable while in OFFER, whatever other ids do.
- A `rd` with valid=0 has no side effect.
- Reset mid-offer: the offer is lost and pending is cleared; the kernel re-arms via `proctimers`.

## Configuration
- `PROC_SCHED_OVERRUN_EN`
  - Defined: adds a sticky `overrun[NUM_PROC-1:0]`. The bit is set when a rise arrives while pending[i]=1 and pending[i] is not being consumed that same cycle. It is readable at adr 2 and cleared by ctrl[5].
  - Undefined: no overrun register; adr 2 reads 0 and ctrl[5] is a no-op.

## Structure
- Shared package `proc_sched_pkg`:
  - `PROC_ID_W = 5`.
  - Ctrl bit indices `PS_SET_PEND` … `PS_CLR_OVR`.
  - Address constants `PS_ADR_OFFER`, `PS_ADR_EN`, `PS_ADR_OVR`.
  - State enum `{PS_IDLE, PS_OFFER}`.
- One sub-module, `rr_pick`: combinational rotate-priority encoder with inputs `req[NUM_PROC]`, `ptr[4:0]` and outputs `any`, `id[4:0]`. The parent holds all state.

## Test plan
- Reset, then enable id 3, then pulse `proc_rdy[3]`: exactly 2 cycles later `irq`=1 and adr0 reads 0x8001_0003. A consuming `rd` gives `irq`=0 next cycle, and `ptr` becomes 4.
- Enable ids 1, 5, 9 with `ptr`=6, then raise all three at once: the offers in order are 9, 1, 5. Popcount reads 3, 2, 1.
- Hold `proc_rdy[2]` high for 20 cycles: exactly one dispatch. Toggling it low then high queues a second.
- While 7 is offered, raise `proc_rdy[4]`: offer stays 7. Then disable 7: next cycle IDLE, the following cycle 4 is offered.
- In the same cycle as consuming id 7, raise `proc_rdy[7]` again: pending[7] stays 1 and 7 is re-offered 2 cycles later; with the macro, overrun[7]=0.
- Macro build: two rises on id 0 with no `rd` in between set adr2 bit 0. Writing ctrl[5] clears it. A write to id 31 with NUM_PROC=16 changes nothing.
